// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle for window_3x3_gen.
// slave: the generator side; master: the pixel source / window consumer side.
interface window_3x3_gen_if;
    logic        pix_valid;
    logic        sof;
    logic [23:0] pix_in;
    logic        window_valid;
    logic [23:0] RGB_Edge;
    logic [7:0]  top;
    logic [7:0]  bot;
    logic [7:0]  left;
    logic [7:0]  right;
    logic [7:0]  top_left;
    logic [7:0]  top_right;
    logic [7:0]  bot_left;
    logic [7:0]  bot_right;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output pix_valid, sof, pix_in,
        input  window_valid, RGB_Edge, top, bot, left, right,
        input  top_left, top_right, bot_left, bot_right,
        input  frame_done, frame_err
    );

    modport slave (
        input  pix_valid, sof, pix_in,
        output window_valid, RGB_Edge, top, bot, left, right,
        output top_left, top_right, bot_left, bot_right,
        output frame_done, frame_err
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator feeding the edge-detect stage.
// Ports: clk, reset (sync, active-high), bus (window_3x3_gen_if.slave):
//   in  pix_valid, sof, pix_in[23:0] (R,G,B)
//   out window_valid, RGB_Edge[23:0] (centre), top/bot/left/right and
//       four corners [7:0] (green), frame_done, frame_err (1-cycle pulses).
// Option macro GRAY_LUMA_EN: convert input to Y=(R+2G+B)>>2 on entry;
//   all channels carry Y and latency grows from 1 to 2 clk.
module window_3x3_gen #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
) (
    input  logic              clk,
    input  logic              reset,
    window_3x3_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t state_q, state_d;

    logic                v_w, sof_w;
    logic [23:0]         px_w;

`ifdef GRAY_LUMA_EN
    logic        v_q, sof_q;
    logic [23:0] px_q;
    logic [9:0]  luma_sum;
    logic [7:0]  luma;

    always_comb begin
        luma_sum = {2'b00, bus.pix_in[23:16]}
                 + {1'b0, bus.pix_in[15:8], 1'b0}
                 + {2'b00, bus.pix_in[7:0]};
        luma     = 8'(luma_sum >> 2);
    end

    // Entry register holding the converted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= 1'b0;
            sof_q <= 1'b0;
            px_q  <= '0;
        end else begin
            v_q   <= bus.pix_valid;
            sof_q <= bus.sof;
            px_q  <= {3{luma}};
        end
    end

    assign v_w   = v_q;
    assign sof_w = sof_q;
    assign px_w  = px_q;
`else
    assign v_w   = bus.pix_valid;
    assign sof_w = bus.sof;
    assign px_w  = bus.pix_in;
`endif

    logic [COL_BITS-1:0] col_q, col_d, cur_col;
    logic [ROW_BITS-1:0] row_q, row_d, cur_row;
    logic                acc, last, emit, err_w;

    logic [23:0] lb0_q [IMG_W];
    logic [7:0]  lb1_q [IMG_W];
    logic [23:0] lb0_rd;
    logic [7:0]  lb1_rd;

    // Two stored window columns: w2 = column c-1, w1 = column c-2.
    logic [7:0]  w1_top_q, w2_top_q;
    logic [7:0]  w1_mid_g_q;
    logic [23:0] w2_mid_q;
    logic [7:0]  w1_bot_q, w2_bot_q;

    logic        wv_q, done_q, err_q;
    logic [23:0] rgb_q;
    logic [7:0]  top_q, bot_q, left_q, right_q;
    logic [7:0]  tl_q, tr_q, bl_q, br_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (acc && last)
            state_d = DONE;
        else if (v_w && sof_w)
            state_d = ACTIVE;
    end

    // sof forces the pixel to (0,0) regardless of state.
    always_comb begin
        acc     = v_w && (sof_w || state_q == ACTIVE);
        cur_col = sof_w ? '0 : col_q;
        cur_row = sof_w ? '0 : row_q;
        last    = (cur_row == ROW_BITS'(IMG_H - 1))
               && (cur_col == COL_BITS'(IMG_W - 1));
        emit    = acc && (cur_row >= ROW_BITS'(2))
                      && (cur_col >= COL_BITS'(2));
        err_w   = v_w && sof_w && (state_q == ACTIVE)
               && ((row_q != '0) || (col_q != '0));
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (cur_col == COL_BITS'(IMG_W - 1)) begin
                col_d = '0;
                row_d = last ? '0 : cur_row + ROW_BITS'(1);
            end else begin
                col_d = cur_col + COL_BITS'(1);
                row_d = cur_row;
            end
        end
    end

    assign lb0_rd = lb0_q[cur_col];
    assign lb1_rd = lb1_q[cur_col];

    // Read-before-write: the reads above see the previous row's data.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[cur_col] <= lb0_rd[15:8];
            lb0_q[cur_col] <= px_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            w1_top_q   <= '0;
            w2_top_q   <= '0;
            w1_mid_g_q <= '0;
            w2_mid_q   <= '0;
            w1_bot_q   <= '0;
            w2_bot_q   <= '0;
            wv_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rgb_q      <= '0;
            top_q      <= '0;
            bot_q      <= '0;
            left_q     <= '0;
            right_q    <= '0;
            tl_q       <= '0;
            tr_q       <= '0;
            bl_q       <= '0;
            br_q       <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            wv_q   <= emit;
            done_q <= acc && last;
            err_q  <= err_w;
            if (acc) begin
                w1_top_q   <= w2_top_q;
                w2_top_q   <= lb1_rd;
                w1_mid_g_q <= w2_mid_q[15:8];
                w2_mid_q   <= lb0_rd;
                w1_bot_q   <= w2_bot_q;
                w2_bot_q   <= px_w[15:8];
            end
            // Incoming column is the right edge of the window.
            if (emit) begin
                rgb_q   <= w2_mid_q;
                top_q   <= w2_top_q;
                bot_q   <= w2_bot_q;
                left_q  <= w1_mid_g_q;
                right_q <= lb0_rd[15:8];
                tl_q    <= w1_top_q;
                tr_q    <= lb1_rd;
                bl_q    <= w1_bot_q;
                br_q    <= px_w[15:8];
            end
        end
    end

    assign bus.window_valid = wv_q;
    assign bus.RGB_Edge     = rgb_q;
    assign bus.top          = top_q;
    assign bus.bot          = bot_q;
    assign bus.left         = left_q;
    assign bus.right        = right_q;
    assign bus.top_left     = tl_q;
    assign bus.top_right    = tr_q;
    assign bus.bot_left     = bl_q;
    assign bus.bot_right    = br_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_err    = err_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on an 8x6 image.
// Pixel (r,c) = {A0^fx, (r*16+c)^fx, 0B}; fx tags an aborted frame.
module tb_window_3x3_gen;
    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    window_3x3_gen_if bus ();

    window_3x3_gen #(
        .IMG_W(W), .IMG_H(H), .COL_BITS(3), .ROW_BITS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int nwin;
    logic [7:0]  fx;
    logic [87:0] exp_bus;
    logic [87:0] obs_bus;

    assign obs_bus = {bus.RGB_Edge, bus.top, bus.bot, bus.left,
                      bus.right, bus.top_left, bus.top_right,
                      bus.bot_left, bus.bot_right};

    function automatic logic [7:0] g(int r, int c);
        return 8'(r * 16 + c) ^ fx;
    endfunction

    function automatic logic [23:0] pix(int r, int c);
        return {8'hA0 ^ fx, g(r, c), 8'h0B};
    endfunction

    function automatic logic [87:0] win(int r, int c);
        return {pix(r-1, c-1), g(r-2, c-1), g(r, c-1), g(r-1, c-2),
                g(r-1, c), g(r-2, c-2), g(r-2, c), g(r, c-2), g(r, c)};
    endfunction

    task automatic chk(string tag, logic [87:0] obs, logic [87:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag, bit ew, bit ed, bit ee);
        chk({tag, " valid"}, 88'(bus.window_valid), 88'(ew));
        chk({tag, " done"},  88'(bus.frame_done),   88'(ed));
        chk({tag, " err"},   88'(bus.frame_err),    88'(ee));
        chk({tag, " win"},   obs_bus,               exp_bus);
        if (bus.window_valid) nwin++;
    endtask

    // Called at a negedge; drives one cycle, checks at the next negedge.
    task automatic step(bit v, bit s, int r, int c,
                        bit ew, bit ed, bit ee);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = v ? pix(r, c) : 24'h5A5A5A;
        @(negedge clk);
        if (ew) exp_bus = win(r, c);
        chk_all($sformatf("px(%0d,%0d)", r, c), ew, ed, ee);
    endtask

    task automatic frame(bit gaps, int sr, int sc, bit first_err);
        nwin = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == sr && c == sc) return;
                step(1'b1, r == 0 && c == 0, r, c,
                     r >= 2 && c >= 2, r == H-1 && c == W-1,
                     first_err && r == 0 && c == 0);
                if (gaps) step(1'b0, 1'b0, r, c, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        reset         = 1'b1;
        fx            = 8'h00;
        exp_bus       = '0;
        nwin          = 0;
        repeat (2) @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

`ifdef GRAY_LUMA_EN
        begin
            bit pe;
            bit pd;
            pe = 1'b0;
            pd = 1'b0;
            for (int r = 0; r <= H; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r < H) begin
                        bus.pix_valid = 1'b1;
                        bus.sof       = (r == 0 && c == 0);
                        bus.pix_in    = 24'h4080C0;
                    end else begin
                        bus.pix_valid = 1'b0;
                        bus.sof       = 1'b0;
                    end
                    @(negedge clk);
                    if (pe) exp_bus = {24'h808080, {8{8'h80}}};
                    chk_all($sformatf("luma(%0d,%0d)", r, c),
                            pe, pd, 1'b0);
                    pe = (r < H) && r >= 2 && c >= 2;
                    pd = (r == H-1) && (c == W-1);
                end
            end
            chk("luma count", 88'(nwin), 88'(24));
        end
`else
        // sof never seen: pixels ignored.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1, i, 1'b0, 1'b0, 1'b0);

        frame(1'b0, -1, -1, 1'b0);
        chk("frame1 count", 88'(nwin), 88'(24));

        // DONE: further pixels ignored, outputs hold.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 3, i, 1'b0, 1'b0, 1'b0);

        frame(1'b1, -1, -1, 1'b0);
        chk("gapped count", 88'(nwin), 88'(24));

        fx = 8'h80;
        frame(1'b0, 3, 4, 1'b0);
        chk("aborted count", 88'(nwin), 88'(8));
        fx = 8'h00;
        frame(1'b0, -1, -1, 1'b1);
        chk("restart count", 88'(nwin), 88'(24));

        frame(1'b0, 4, 5, 1'b0);
        reset         = 1'b1;
        bus.pix_valid = 1'b1;
        bus.sof       = 1'b0;
        bus.pix_in    = pix(4, 5);
        @(negedge clk);
        exp_bus = '0;
        chk_all("mid reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        frame(1'b0, -1, -1, 1'b0);
        chk("post reset count", 88'(nwin), 88'(24));
`endif

        bus.pix_valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
